// File: rtl/riscv_types.sv
// riscv_types
//   Shared execute-stage definitions.
//   FP_BIAS            : single-precision exponent bias.
//   exe_p_mux_bus_type : instruction sideband carried alongside pipeline tokens.
package riscv_types;

  localparam logic [7:0] FP_BIAS = 8'd127;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        FP_reg_write;
  } exe_p_mux_bus_type;

endpackage

// File: rtl/fp_unpack_class.sv
// fp_unpack_class
//   Combinational unpack and classification of one IEEE-754 single operand.
//   num_i     : packed single-precision operand
//   mant_o    : {hidden, frac}, hidden set for normal numbers
//   exp_o     : effective exponent (1 for subnormals/zero)
//   is_nan_o, is_inf_o, is_zero_o : operand class
module fp_unpack_class (
  input  logic [31:0] num_i,
  output logic [23:0] mant_o,
  output logic [7:0]  exp_o,
  output logic        is_nan_o,
  output logic        is_inf_o,
  output logic        is_zero_o
);

  logic exp_zero_s;
  logic exp_ones_s;
  logic frac_zero_s;

  assign exp_zero_s  = (num_i[30:23] == 8'h00);
  assign exp_ones_s  = (num_i[30:23] == 8'hFF);
  assign frac_zero_s = (num_i[22:0] == 23'd0);

  assign mant_o    = {~exp_zero_s, num_i[22:0]};
  // Subnormals share the scale of exponent 1, just without the hidden bit.
  assign exp_o     = exp_zero_s ? 8'd1 : num_i[30:23];
  assign is_nan_o  = exp_ones_s & ~frac_zero_s;
  assign is_inf_o  = exp_ones_s & frac_zero_s;
  assign is_zero_o = exp_zero_s & frac_zero_s;

endmodule

// File: rtl/fmul_prod_r4.sv
// fmul_prod_r4
//   Two-stage (M1, M2) single-precision multiply front end for a fused
//   multiply-add. M1 unpacks and forms the raw 48-bit product, M2 normalises
//   it and resolves special cases. num3/add_sub/rm ride along for the adder.
//   clk, rst (async, active low), en (advance), clear[1:0] (flush M1/M2)
//   num1, num2, neg_prod  : multiplicands and product-sign inversion
//   num3, add_sub, rm     : forwarded to num3_o, add_sub_o, rm_o
//   p_start / p_result    : valid token in / out
//   pipe_i / pipe_o       : instruction sideband
//   prod_*                : normalised product and class flags
//   uu_rd, uu_reg_write, uu_FP_reg_write : per-stage rd and write enables
module fmul_prod_r4
  import riscv_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        clear,
  input  logic [31:0]       num1,
  input  logic [31:0]       num2,
  input  logic [31:0]       num3,
  input  logic              neg_prod,
  input  logic              add_sub,
  input  logic [2:0]        rm,
  input  logic              p_start,
  input  exe_p_mux_bus_type pipe_i,
  output logic              p_result,
  output exe_p_mux_bus_type pipe_o,
  output logic [7:0]        prod_exp,
  output logic [46:0]       prod_mant,
  output logic              prod_sign,
  output logic              prod_is_NaN,
  output logic              prod_is_inf,
  output logic              prod_is_zero,
  output logic [31:0]       num3_o,
  output logic              add_sub_o,
  output logic [2:0]        rm_o,
  output logic [4:0]        uu_rd [0:1],
  output logic [1:0]        uu_reg_write,
  output logic [1:0]        uu_FP_reg_write
);

  typedef struct packed {
    logic              p;
    exe_p_mux_bus_type bus;
    logic [47:0]       prod;
    logic              sign;
    logic [9:0]        exp;   // two's complement e1+e2-bias
    logic              nan;
    logic              inf;
    logic              zero;
    logic [31:0]       num3;
    logic              add_sub;
    logic [2:0]        rm;
  } m1_t;

  typedef struct packed {
    logic              p;
    exe_p_mux_bus_type bus;
    logic [7:0]        exp;
    logic [46:0]       mant;
    logic              sign;
    logic              nan;
    logic              inf;
    logic              zero;
    logic [31:0]       num3;
    logic              add_sub;
    logic [2:0]        rm;
  } m2_t;

  m1_t m1_d, m1_q;
  m2_t m2_d, m2_q;

  logic [23:0] mant_a_s, mant_b_s;
  logic [7:0]  exp_a_s, exp_b_s;
  logic        nan_a_s, inf_a_s, zero_a_s;
  logic        nan_b_s, inf_b_s, zero_b_s;

  fp_unpack_class u_unpack_a (
    .num_i     (num1),
    .mant_o    (mant_a_s),
    .exp_o     (exp_a_s),
    .is_nan_o  (nan_a_s),
    .is_inf_o  (inf_a_s),
    .is_zero_o (zero_a_s)
  );

  fp_unpack_class u_unpack_b (
    .num_i     (num2),
    .mant_o    (mant_b_s),
    .exp_o     (exp_b_s),
    .is_nan_o  (nan_b_s),
    .is_inf_o  (inf_b_s),
    .is_zero_o (zero_b_s)
  );

  // Stage M1 next state: raw product, sign, biased exponent sum, class flags.
  always_comb begin
    m1_d         = '0;
    m1_d.p       = p_start;
    m1_d.bus     = pipe_i;
    m1_d.prod    = {24'd0, mant_a_s} * {24'd0, mant_b_s};
    m1_d.sign    = num1[31] ^ num2[31] ^ neg_prod;
    m1_d.exp     = {2'b00, exp_a_s} + {2'b00, exp_b_s} - {2'b00, FP_BIAS};
    // inf * 0 is invalid and folds into NaN here so M2 sees one flag.
    m1_d.nan     = nan_a_s | nan_b_s | (inf_a_s & zero_b_s) | (zero_a_s & inf_b_s);
    m1_d.inf     = inf_a_s | inf_b_s;
    m1_d.zero    = zero_a_s | zero_b_s;
    m1_d.num3    = num3;
    m1_d.add_sub = add_sub;
    m1_d.rm      = rm;
  end

  logic signed [9:0] norm_exp_s;
  logic              ovf_s;
  logic              unf_s;

  assign norm_exp_s = $signed(m1_q.exp) + $signed({9'd0, m1_q.prod[47]});
  assign ovf_s      = (norm_exp_s > 10'sd254);
  assign unf_s      = (norm_exp_s < 10'sd1);

  // Stage M2 next state: normalise and resolve NaN > inf > zero priority.
  always_comb begin
    m2_d         = '0;
    m2_d.p       = m1_q.p;
    m2_d.bus     = m1_q.bus;
    m2_d.sign    = m1_q.sign;
    m2_d.num3    = m1_q.num3;
    m2_d.add_sub = m1_q.add_sub;
    m2_d.rm      = m1_q.rm;
    if (m1_q.nan) begin
      m2_d.nan  = 1'b1;
      m2_d.exp  = 8'hFF;
      m2_d.mant = {2'b01, 45'd0};
    end else if (m1_q.inf || ovf_s) begin
      m2_d.inf  = 1'b1;
      m2_d.exp  = 8'hFF;
      m2_d.mant = 47'd0;
    end else if (m1_q.zero || unf_s) begin
      m2_d.zero = 1'b1;
      m2_d.exp  = 8'h00;
      m2_d.mant = 47'd0;
    end else if (m1_q.prod[47]) begin
      // Shift right by one, folding the dropped bit into a sticky LSB.
      m2_d.exp  = norm_exp_s[7:0];
      m2_d.mant = {m1_q.prod[47:2], m1_q.prod[1] | m1_q.prod[0]};
    end else begin
      m2_d.exp  = norm_exp_s[7:0];
      m2_d.mant = m1_q.prod[46:0];
    end
  end

  // Pipeline registers: reset, then per-stage clear, then enable; else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_q <= '0;
      m2_q <= '0;
    end else begin
      if (clear[0]) begin
        m1_q <= '0;
      end else if (en) begin
        m1_q <= m1_d;
      end
      if (clear[1]) begin
        m2_q <= '0;
      end else if (en) begin
        m2_q <= m2_d;
      end
    end
  end

  assign p_result        = m2_q.p;
  assign pipe_o          = m2_q.bus;
  assign prod_exp        = m2_q.exp;
  assign prod_mant       = m2_q.mant;
  assign prod_sign       = m2_q.sign;
  assign prod_is_NaN     = m2_q.nan;
  assign prod_is_inf     = m2_q.inf;
  assign prod_is_zero    = m2_q.zero;
  assign num3_o          = m2_q.num3;
  assign add_sub_o       = m2_q.add_sub;
  assign rm_o            = m2_q.rm;
  assign uu_rd[0]        = m1_q.bus.rd;
  assign uu_rd[1]        = m2_q.bus.rd;
  assign uu_reg_write    = {m2_q.bus.reg_write, m1_q.bus.reg_write};
  assign uu_FP_reg_write = {m2_q.bus.FP_reg_write, m1_q.bus.FP_reg_write};

endmodule

// File: tb/tb_fmul_prod_r4.sv
// tb_fmul_prod_r4
//   Self-checking bench for fmul_prod_r4: directed vector table, random
//   stream against a behavioural two-stage model, and hand-written
//   clear / stall / reset sequences.
module tb_fmul_prod_r4;
  import riscv_types::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic [1:0]        clear = 2'b00;
  logic [31:0]       num1 = 32'd0, num2 = 32'd0, num3 = 32'd0;
  logic              neg_prod = 1'b0, add_sub = 1'b0;
  logic [2:0]        rm = 3'd0;
  logic              p_start = 1'b0;
  exe_p_mux_bus_type pipe_i = '0;
  logic              p_result;
  exe_p_mux_bus_type pipe_o;
  logic [7:0]        prod_exp;
  logic [46:0]       prod_mant;
  logic              prod_sign, prod_is_NaN, prod_is_inf, prod_is_zero;
  logic [31:0]       num3_o;
  logic              add_sub_o;
  logic [2:0]        rm_o;
  logic [4:0]        uu_rd [0:1];
  logic [1:0]        uu_reg_write, uu_FP_reg_write;

  fmul_prod_r4 dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .num1(num1), .num2(num2), .num3(num3), .neg_prod(neg_prod),
    .add_sub(add_sub), .rm(rm), .p_start(p_start), .pipe_i(pipe_i),
    .p_result(p_result), .pipe_o(pipe_o), .prod_exp(prod_exp),
    .prod_mant(prod_mant), .prod_sign(prod_sign), .prod_is_NaN(prod_is_NaN),
    .prod_is_inf(prod_is_inf), .prod_is_zero(prod_is_zero), .num3_o(num3_o),
    .add_sub_o(add_sub_o), .rm_o(rm_o), .uu_rd(uu_rd),
    .uu_reg_write(uu_reg_write), .uu_FP_reg_write(uu_FP_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              p;
    logic [7:0]        e;
    logic [46:0]       m;
    logic              s, nan, inf, zero;
    logic [31:0]       n3;
    logic              as;
    logic [2:0]        rm;
    exe_p_mux_bus_type bus;
  } rec_t;

  typedef struct packed {
    logic [31:0] a, b;
    logic        np;
    logic [7:0]  e;
    logic [46:0] m;
    logic        s, nan, inf, zero;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  rec_t s1 = '0, s2 = '0;   // expected contents of M1 and M2

  // Reference: product of two singles per the IEEE rules, truncated with sticky.
  function automatic rec_t model_tok(logic [31:0] a, logic [31:0] b, logic np);
    rec_t r = '0;
    int unsigned ea_raw = a[30:23], eb_raw = b[30:23];
    longint unsigned ma = a[22:0], mb = b[22:0], p, mant;
    int  ea, eb, e;
    bit  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    nan_a  = (ea_raw == 255) && (ma != 0);
    nan_b  = (eb_raw == 255) && (mb != 0);
    inf_a  = (ea_raw == 255) && (ma == 0);
    inf_b  = (eb_raw == 255) && (mb == 0);
    zero_a = (ea_raw == 0) && (ma == 0);
    zero_b = (eb_raw == 0) && (mb == 0);
    if (ea_raw != 0) ma = ma + 64'd8388608;
    if (eb_raw != 0) mb = mb + 64'd8388608;
    ea = (ea_raw == 0) ? 1 : int'(ea_raw);
    eb = (eb_raw == 0) ? 1 : int'(eb_raw);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= 64'h8000_0000_0000) begin
      e    = e + 1;
      mant = (p / 4) * 2 + (((p % 4) != 0) ? 64'd1 : 64'd0);
    end else begin
      mant = p;
    end
    r.s   = a[31] ^ b[31] ^ np;
    r.nan = nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b);
    r.inf = !r.nan && (inf_a || inf_b || e > 254);
    r.zero = !r.nan && !r.inf && (zero_a || zero_b || e < 1);
    r.e   = r.zero ? 8'd0 : 8'(e);
    r.m   = r.zero ? 47'd0 : 47'(mant);
    return r;
  endfunction

  // Data fields are only defined for valid tokens; exp/mant not for NaN/inf.
  function automatic rec_t mask(rec_t r, rec_t ref_r);
    rec_t o = r;
    if (!ref_r.p) begin
      o.e = 8'd0; o.m = 47'd0; o.s = 1'b0;
      o.nan = 1'b0; o.inf = 1'b0; o.zero = 1'b0;
    end else if (ref_r.nan || ref_r.inf) begin
      o.e = 8'd0; o.m = 47'd0;
    end
    return o;
  endfunction

  function automatic rec_t got_rec();
    return {p_result, prod_exp, prod_mant, prod_sign, prod_is_NaN, prod_is_inf,
            prod_is_zero, num3_o, add_sub_o, rm_o, pipe_o};
  endfunction

  task automatic cmp(input string name, input logic [255:0] got, input logic [255:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp_v);
    end
  endtask

  // Whole output state against the model of both stages.
  task automatic check_state(input string name);
    logic [255:0] g, x;
    g = {mask(got_rec(), s2), uu_rd[0], uu_rd[1], uu_reg_write, uu_FP_reg_write};
    x = {mask(s2, s2), s1.bus.rd, s2.bus.rd,
         s2.bus.reg_write, s1.bus.reg_write, s2.bus.FP_reg_write, s1.bus.FP_reg_write};
    cmp(name, g, x);
  endtask

  // Advance the model by one edge with the currently driven inputs, then check.
  task automatic tick(input string name);
    rec_t n1;
    n1 = model_tok(num1, num2, neg_prod);
    n1.p = p_start; n1.n3 = num3; n1.as = add_sub; n1.rm = rm; n1.bus = pipe_i;
    if (clear[1]) s2 = '0; else if (en) s2 = s1;
    if (clear[0]) s1 = '0; else if (en) s1 = n1;
    @(negedge clk);
    check_state(name);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic np, input logic ps);
    num1 = a; num2 = b; neg_prod = np; p_start = ps;
    num3 = a ^ b; add_sub = a[0] ^ b[1]; rm = 3'(a[2:0] + b[2:0]);
    pipe_i = {a ^ 32'h1234_5678, 5'(b[6:2]), a[4], b[5]};
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v = $urandom;
    case ($urandom_range(0, 7))
      0: v[30:0] = 31'd0;
      1: v[30:0] = {8'hFF, 23'd0};
      2: v[30:23] = 8'hFF;
      3: v[30:23] = 8'h00;
      4: v[30:23] = 8'($urandom_range(1, 5));
      5: v[30:23] = 8'($urandom_range(250, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  vec_t vt [14];

  initial begin
    vt[0]  = '{32'h40000000, 32'h40400000, 1'b0, 8'h81, 47'h600000000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'h7F000000, 32'h7F000000, 1'b0, 8'h00, 47'h0,            1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{32'h00800000, 32'h00800000, 1'b0, 8'h00, 47'h0,            1'b0, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 8'h00, 47'h0,            1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{32'h7F800000, 32'h00000000, 1'b0, 8'h00, 47'h0,            1'b0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{32'h80000000, 32'h40A00000, 1'b1, 8'h00, 47'h0,            1'b0, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{32'h3F800000, 32'h3F800000, 1'b0, 8'h7F, 47'h400000000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'hC0000000, 32'h3FC00000, 1'b0, 8'h80, 47'h600000000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 8'h80, 47'h7FFFFF000001, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{32'h7F000000, 32'h3F800000, 1'b0, 8'hFE, 47'h400000000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{32'h00800000, 32'h3F800000, 1'b0, 8'h01, 47'h400000000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{32'h00800000, 32'h3F000000, 1'b0, 8'h00, 47'h0,            1'b0, 1'b0, 1'b0, 1'b1};
    vt[12] = '{32'h7F7FFFFF, 32'h3FFFFFFF, 1'b0, 8'h00, 47'h0,            1'b0, 1'b0, 1'b1, 1'b0};
    vt[13] = '{32'hFF800000, 32'h40000000, 1'b0, 8'h00, 47'h0,            1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state.
    #12;
    check_state("reset_state");
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;

    // Directed vectors: token in, two enabled edges, then compare constants.
    for (int i = 0; i < 14; i++) begin
      logic        msk;
      logic [55:0] ge, xe;
      drive(vt[i].a, vt[i].b, vt[i].np, 1'b1);
      tick("vec_m1");
      drive(32'd0, 32'd0, 1'b0, 1'b0);
      tick("vec_m2");
      msk = vt[i].nan | vt[i].inf;
      ge  = msk ? 56'd0 : {prod_exp, prod_mant, 1'b0};
      xe  = msk ? 56'd0 : {vt[i].e, vt[i].m, 1'b0};
      cmp($sformatf("vec%0d", i),
          {p_result, prod_sign, prod_is_NaN, prod_is_inf, prod_is_zero, ge},
          {1'b1, vt[i].s, vt[i].nan, vt[i].inf, vt[i].zero, xe});
    end

    // Random stream with random stalls.
    for (int c = 0; c < 400; c++) begin
      drive(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
      en = ($urandom_range(0, 3) != 0);
      tick("rand");
    end
    en = 1'b1;

    // Back-to-back tokens, M1 flushed as the second arrives: only A emerges.
    drive(32'h40000000, 32'h40400000, 1'b0, 1'b1);
    tick("clr_a");
    drive(32'h3F800000, 32'h40800000, 1'b0, 1'b1);
    clear = 2'b01;
    tick("clr_b");
    cmp("clr_a_out", {p_result, prod_exp}, {1'b1, 8'h81});
    clear = 2'b00;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    tick("clr_c");
    cmp("clr_b_gone", {31'd0, p_result}, 32'd0);

    // Stall for three cycles with two tokens in flight.
    drive(32'h40000000, 32'h40400000, 1'b0, 1'b1);
    tick("stall_a");
    drive(32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
    tick("stall_b");
    en = 1'b0;
    drive(32'h7F800000, 32'h00000000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick("stall_hold");
      cmp("stall_frozen", {p_result, prod_exp, prod_mant}, {1'b1, 8'h81, 47'h600000000000});
    end
    en = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    tick("stall_rel");
    cmp("stall_next", {p_result, prod_exp, prod_mant}, {1'b1, 8'h7F, 47'h400000000000});

    // Reset mid-flight with two tokens, asserted away from any edge.
    drive(32'h40000000, 32'h40400000, 1'b0, 1'b1);
    tick("rst_a");
    tick("rst_b");
    #2;
    rst = 1'b0;
    #1;
    s1 = '0; s2 = '0;
    check_state("rst_async");
    cmp("rst_outs_zero",
        {got_rec(), uu_rd[0], uu_rd[1], uu_reg_write, uu_FP_reg_write}, 256'd0);
    @(negedge clk);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick("rst_rel1");
    cmp("rst_no_tok1", {31'd0, p_result}, 32'd0);
    tick("rst_rel2");
    cmp("rst_no_tok2", {31'd0, p_result}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
